// File: rtl/spi_frame_tx_if.sv
// Handshake and serial-link bundle for spi_frame_tx.
// master: upstream word source (drives data/last/ena, watches status and link).
// slave : the transmitter itself.
interface spi_frame_tx_if #(
   parameter int unsigned WordW = 16
);
   logic [WordW-1:0] data;
   logic             last;
   logic             ena;
   logic             busy;
   logic             word_done;
   logic             tx_clk;
   logic             tx_data;
   logic             tx_load;
   logic             tx_stop;

   modport master (
      output data, last, ena,
      input  busy, word_done, tx_clk, tx_data, tx_load, tx_stop
   );

   modport slave (
      input  data, last, ena,
      output busy, word_done, tx_clk, tx_data, tx_load, tx_stop
   );
endinterface

// File: rtl/spi_frame_tx.sv
// Word-oriented serial transmitter for the CLK/DATA/LOAD/STOP link.
// Each accepted word is shifted out MSB-first, one bit per 2*ClkDiv cycles
// (serial clock low for the first half, high for the second), followed by a
// LOAD bit period and, for the final word of a message, a STOP bit period.
// Optional macro SPI_FRAME_TX_PARITY_EN appends an odd-parity bit period
// after the LSB, before LOAD.
module spi_frame_tx #(
   parameter int unsigned ClkDiv = 4,   // cycles per serial half-period, 1..255
   parameter int unsigned WordW  = 16
) (
   input logic           clk_i,
   input logic           rst_i,
   spi_frame_tx_if.slave bus
);

`ifdef SPI_FRAME_TX_PARITY_EN
   // Parity travels as an extra LSB of the shift register.
   localparam int unsigned NBits = WordW + 1;
`else
   localparam int unsigned NBits = WordW;
`endif
   localparam int unsigned        BitCntW  = $clog2(WordW + 1);
   localparam logic [7:0]         HalfLast = 8'(ClkDiv - 1);
   localparam logic [BitCntW-1:0] BitLast  = BitCntW'(NBits - 1);

   typedef enum logic [1:0] {StIdle, StShift, StLoad, StStop} state_e;

   state_e             state_q;
   logic [NBits-1:0]   shreg_q;
   logic               last_q;
   logic [7:0]         hcnt_q;
   logic               high_q;      // currently in the high half of the bit period
   logic [BitCntW-1:0] bit_cnt_q;

   logic busy_q;
   logic word_done_q;
   logic tx_clk_q;
   logic tx_data_q;
   logic tx_load_q;
   logic tx_stop_q;

   logic [NBits-1:0] capture;
   logic             half_end;
   logic             period_end;

`ifdef SPI_FRAME_TX_PARITY_EN
   assign capture = {bus.data, ~^bus.data};
`else
   assign capture = bus.data;
`endif

   assign half_end   = (hcnt_q == HalfLast);
   assign period_end = half_end & high_q;

   // Frame sequencer: half-period timing, shifting and all registered link outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         shreg_q     <= '0;
         last_q      <= 1'b0;
         hcnt_q      <= '0;
         high_q      <= 1'b0;
         bit_cnt_q   <= '0;
         busy_q      <= 1'b0;
         word_done_q <= 1'b0;
         tx_clk_q    <= 1'b0;
         tx_data_q   <= 1'b0;
         tx_load_q   <= 1'b0;
         tx_stop_q   <= 1'b0;
      end else begin
         word_done_q <= 1'b0;

         // Serial clock runs only while a frame is in flight, so it idles low.
         if (state_q != StIdle) begin
            if (half_end) begin
               hcnt_q   <= '0;
               high_q   <= ~high_q;
               tx_clk_q <= ~high_q;
            end else begin
               hcnt_q <= hcnt_q + 8'd1;
            end
         end

         unique case (state_q)
            StIdle: begin
               if (bus.ena) begin
                  shreg_q   <= capture;
                  last_q    <= bus.last;
                  state_q   <= StShift;
                  busy_q    <= 1'b1;
                  tx_data_q <= capture[NBits-1];
                  tx_clk_q  <= 1'b0;
                  hcnt_q    <= '0;
                  high_q    <= 1'b0;
                  bit_cnt_q <= '0;
               end
            end

            StShift: begin
               if (period_end) begin
                  shreg_q   <= shreg_q << 1;
                  bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                  if (bit_cnt_q == BitLast) begin
                     state_q   <= StLoad;
                     tx_data_q <= 1'b0;
                     tx_load_q <= 1'b1;
                  end else begin
                     tx_data_q <= shreg_q[NBits-2];
                  end
               end
            end

            StLoad: begin
               if (period_end) begin
                  tx_load_q <= 1'b0;
                  if (last_q) begin
                     state_q   <= StStop;
                     tx_stop_q <= 1'b1;
                  end else begin
                     state_q     <= StIdle;
                     busy_q      <= 1'b0;
                     word_done_q <= 1'b1;
                  end
               end
            end

            StStop: begin
               if (period_end) begin
                  tx_stop_q   <= 1'b0;
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  word_done_q <= 1'b1;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.word_done = word_done_q;
   assign bus.tx_clk    = tx_clk_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_load   = tx_load_q;
   assign bus.tx_stop   = tx_stop_q;

   // Markers never overlap, and a completed word always leaves the link free.
   a_markers_exclusive : assert property (@(posedge clk_i) disable iff (rst_i)
      !(tx_load_q && tx_stop_q));
   a_done_not_busy : assert property (@(posedge clk_i) disable iff (rst_i)
      word_done_q |-> !busy_q);

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two instances (ClkDiv 2 and 1) checked every cycle
// against a frame-level model, plus literal expectations from the test plan.
module tb_spi_frame_tx;

   localparam int unsigned W   = 16;
   localparam int unsigned Cd0 = 2;
   localparam int unsigned Cd1 = 1;
`ifdef SPI_FRAME_TX_PARITY_EN
   localparam int Par = 1;
`else
   localparam int Par = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         ena  [2];
   logic [W-1:0] data [2];
   logic         last [2];
   // {busy, word_done, tx_clk, tx_data, tx_load, tx_stop}
   logic [5:0]   obs  [2];

   spi_frame_tx_if #(.WordW(W)) bus0 ();
   spi_frame_tx_if #(.WordW(W)) bus1 ();

   assign bus0.ena  = ena[0];
   assign bus0.data = data[0];
   assign bus0.last = last[0];
   assign bus1.ena  = ena[1];
   assign bus1.data = data[1];
   assign bus1.last = last[1];
   assign obs[0] = {bus0.busy, bus0.word_done, bus0.tx_clk, bus0.tx_data, bus0.tx_load,
                    bus0.tx_stop};
   assign obs[1] = {bus1.busy, bus1.word_done, bus1.tx_clk, bus1.tx_data, bus1.tx_load,
                    bus1.tx_stop};

   spi_frame_tx #(.ClkDiv(Cd0), .WordW(W)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
   spi_frame_tx #(.ClkDiv(Cd1), .WordW(W)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // ---------------- frame-level model ----------------
   bit           m_act  [2];
   bit           m_done [2];
   int           m_t    [2];   // cycles since acceptance, 1-based
   logic [W-1:0] m_word [2];
   bit           m_last [2];

   function automatic int cd_of(int i);
      return (i == 0) ? int'(Cd0) : int'(Cd1);
   endfunction

   function automatic int frame_len(int i, bit lst);
      return (W + 1 + Par + (lst ? 1 : 0)) * 2 * cd_of(i);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
            m_t[i]    = 0;
         end else if (m_act[i]) begin
            if (m_t[i] == frame_len(i, m_last[i])) begin
               m_act[i]  = 1'b0;
               m_done[i] = 1'b1;
            end else begin
               m_t[i]++;
            end
         end else begin
            m_done[i] = 1'b0;
            if (ena[i]) begin
               m_act[i]  = 1'b1;
               m_t[i]    = 1;
               m_word[i] = data[i];
               m_last[i] = last[i];
            end
         end
      end
   end

   function automatic logic [5:0] model_out(int i);
      logic [5:0]   r;
      logic [W-1:0] w;
      int           p, ph, c;
      r = '0;
      c = cd_of(i);
      if (!m_act[i]) begin
         r[4] = m_done[i];
         return r;
      end
      p    = (m_t[i] - 1) / (2 * c);
      ph   = (m_t[i] - 1) % (2 * c);
      r[5] = 1'b1;
      r[3] = (ph >= c);
      w    = m_word[i];
      if (p < int'(W))                 r[2] = w[W-1-p];
      else if (Par == 1 && p == int'(W)) r[2] = ~^w;
      else if (p == int'(W) + Par)     r[1] = 1'b1;
      else                             r[0] = 1'b1;
      return r;
   endfunction

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++)
         chk($sformatf("outputs_dut%0d_t%0t", i, $time), 32'(obs[i]), 32'(model_out(i)));
   end

   // ---------------- link monitor ----------------
   int         rise_n [2];
   int         busy_n [2];
   logic [2:0] rise_rec [2][64];   // {tx_data, tx_load, tx_stop} at each tx_clk rise
   bit         prev_clk [2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (obs[i][5]) busy_n[i]++;
         if (obs[i][3] && !prev_clk[i]) begin
            if (rise_n[i] < 64) rise_rec[i][rise_n[i]] = obs[i][2:0];
            rise_n[i]++;
         end
         prev_clk[i] = obs[i][3];
      end
   end

   task automatic clear_mon(int i);
      rise_n[i] = 0;
      busy_n[i] = 0;
   endtask

   function automatic logic [2:0] rec(int i, int k);
      return rise_rec[i][k-1];
   endfunction

   function automatic logic [W-1:0] rise_word(int i, int first);
      logic [W-1:0] w;
      for (int j = 0; j < int'(W); j++) w[W-1-j] = rise_rec[i][first-1+j][2];
      return w;
   endfunction

   function automatic int marker_count(int i);
      int n = 0;
      for (int k = 0; k < rise_n[i] && k < 64; k++)
         if (rise_rec[i][k][1:0] != 2'b00) n++;
      return n;
   endfunction

   task automatic send(int i, logic [W-1:0] d, bit l);
      data[i] = d;
      last[i] = l;
      ena[i]  = 1'b1;
      @(negedge clk);
      ena[i]  = 1'b0;
   endtask

   task automatic wait_done(int i, int budget, string name);
      int n = 0;
      while (!obs[i][4] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(obs[i][4]), 32'd1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int n;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ena[i]  = 1'b0;
         data[i] = '0;
         last[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("reset_dut0", 32'(obs[0]), 32'd0);
      chk("reset_dut1", 32'(obs[1]), 32'd0);
      rst = 1'b0;

      // A: single last word 0xA5C3.
      @(negedge clk); #1;
      clear_mon(0);
      send(0, 16'hA5C3, 1'b1);
      wait_done(0, 300, "a_done");
      #1;
      chk("a_bits", 32'(rise_word(0, 1)), 32'h0000_A5C3);
      chk("a_load_rise", 32'(rec(0, 17 + Par)), 32'h2);
      chk("a_stop_rise", 32'(rec(0, 18 + Par)), 32'h1);
      chk("a_rises", 32'(rise_n[0]), 32'(18 + Par));
      chk("a_busy", 32'(busy_n[0]), 32'(72 + 4 * Par));

      // B: back-to-back 0x0001 (not last) then 0x8000 (last), ENA held high.
      @(negedge clk); #1;
      clear_mon(0);
      data[0] = 16'h0001;
      last[0] = 1'b0;
      ena[0]  = 1'b1;
      wait_done(0, 300, "b_done1");
      data[0] = 16'h8000;
      last[0] = 1'b1;
      @(negedge clk);
      chk("b_accept_on_done", 32'(obs[0][5]), 32'd1);
      ena[0] = 1'b0;
      wait_done(0, 300, "b_done2");
      #1;
      chk("b_bits1", 32'(rise_word(0, 1)), 32'h0000_0001);
      chk("b_load1", 32'(rec(0, 17 + Par)), 32'h2);
      chk("b_bits2", 32'(rise_word(0, 18 + Par)), 32'h0000_8000);
      chk("b_load2", 32'(rec(0, 34 + 2 * Par)), 32'h2);
      chk("b_stop2", 32'(rec(0, 35 + 2 * Par)), 32'h1);
      chk("b_rises", 32'(rise_n[0]), 32'(35 + 2 * Par));
      chk("b_busy", 32'(busy_n[0]), 32'(140 + 8 * Par));

      // C: ENA with 0xFFFF/LAST=1 mid-frame of 0x1234 (not last) is ignored.
      @(negedge clk); #1;
      clear_mon(0);
      send(0, 16'h1234, 1'b0);
      repeat (20) @(negedge clk);
      data[0] = 16'hFFFF;
      last[0] = 1'b1;
      ena[0]  = 1'b1;
      @(negedge clk);
      ena[0] = 1'b0;
      chk("c_busy_held", 32'(obs[0][5]), 32'd1);
      wait_done(0, 300, "c_done");
      #1;
      chk("c_bits", 32'(rise_word(0, 1)), 32'h0000_1234);
      chk("c_load", 32'(rec(0, 17 + Par)), 32'h2);
      chk("c_rises", 32'(rise_n[0]), 32'(17 + Par));
      chk("c_busy", 32'(busy_n[0]), 32'(68 + 4 * Par));

      // D: reset during the 5th bit of 0xFFFF, then a clean 0x00FF.
      @(negedge clk); #1;
      clear_mon(0);
      send(0, 16'hFFFF, 1'b1);
      n = 0;
      while (rise_n[0] < 5 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      chk("d_reach_bit5", 32'(rise_n[0]), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("d_reset_outputs", 32'(obs[0]), 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("d_no_markers", 32'(marker_count(0)), 32'd0);
      chk("d_rises", 32'(rise_n[0]), 32'd5);
      clear_mon(0);
      send(0, 16'h00FF, 1'b0);
      wait_done(0, 300, "d_done");
      #1;
      chk("d_bits", 32'(rise_word(0, 1)), 32'h0000_00FF);
      chk("d_rises2", 32'(rise_n[0]), 32'(17 + Par));
      chk("d_busy", 32'(busy_n[0]), 32'(68 + 4 * Par));

      // E: ClkDiv=1 instance, 0x0000 not last.
      @(negedge clk); #1;
      clear_mon(1);
      send(1, 16'h0000, 1'b0);
      wait_done(1, 200, "e_done");
      #1;
      chk("e_bits", 32'(rise_word(1, 1)), 32'h0);
      chk("e_rises", 32'(rise_n[1]), 32'(17 + Par));
      chk("e_busy", 32'(busy_n[1]), 32'(34 + 2 * Par));

`ifdef SPI_FRAME_TX_PARITY_EN
      // F: parity bit for 0x0003 is 1.
      @(negedge clk); #1;
      clear_mon(0);
      send(0, 16'h0003, 1'b1);
      wait_done(0, 300, "f_done");
      #1;
      chk("f_bits", 32'(rise_word(0, 1)), 32'h0000_0003);
      chk("f_parity", 32'(rec(0, 17)), 32'h4);
      chk("f_load", 32'(rec(0, 18)), 32'h2);
      chk("f_stop", 32'(rec(0, 19)), 32'h1);
      chk("f_busy", 32'(busy_n[0]), 32'd76);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Word-oriented serial transmitter for the board's SPI-like link (CLK/DATA/LOAD/STOP).
- Takes 16-bit big-endian words from the Cypress-side read path through an ENA/BUSY handshake.
- Shifts each word out MSB-first on a self-generated serial clock, marks each word with a LOAD period, and marks the end of a message with a STOP period.
- It is the transmit counterpart of the link deserializer.

Parameters:
- CLK_DIV, 4: SYS_CLK cycles per serial-clock half-period; legal values are 1..255.
- WORD_W, 16: bits per word.

Ports:
- SYS_CLK  in  1  system clock (ifclk domain).
- RST  in  1  reset; synchronous, active-high.
- DATA  in  WORD_W  word to send, big-endian.
- LAST  in  1  qualifies DATA as the final word of a message.
- ENA  in  1  word valid; accepted only when BUSY=0.
- BUSY  out  1  transmitter occupied; ENA is ignored while high.
- WORD_DONE  out  1  one-cycle pulse when a word's frame, including LOAD/STOP, has fully completed.
- TX_CLK  out  1  serial clock; idles low.
- TX_DATA  out  1  serial data; changes on TX_CLK falling edges and is stable across rising edges.
- TX_LOAD  out  1  word-boundary marker.
- TX_STOP  out  1  message-end marker.

Behaviour:
- Reset: BUSY=0, WORD_DONE=0, TX_CLK=0, TX_DATA=0, TX_LOAD=0, TX_STOP=0, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame at the next edge. No LOAD or STOP is emitted for the partial word.
- Bit period:
  - One bit period = 2*CLK_DIV SYS_CLK cycles.
  - TX_CLK is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
  - The receiver samples on the rising edge.
- FSM states: IDLE, SHIFT, LOAD, STOP.
  - IDLE: BUSY=0. When ENA=1, capture DATA into the shift register and LAST into a flag, go to SHIFT, and set BUSY=1 from the next cycle.
  - SHIFT: TX_DATA=shreg[MSB] for the whole bit period. At the end of each period, shift left and increment the bit counter. After WORD_W periods, go to LOAD.
  - LOAD: one bit period with TX_LOAD=1, TX_DATA=0, TX_CLK still toggling. At its end, go to STOP if the LAST flag is set, otherwise go to IDLE.
  - STOP: one bit period with TX_STOP=1, TX_DATA=0, TX_LOAD=0. At its end, go to IDLE.
- WORD_DONE pulses on the cycle the FSM re-enters IDLE; BUSY drops on that same cycle.
- Latency: the first data bit is on TX_DATA in the cycle after acceptance, with TX_CLK low.
- Frame length in SYS_CLK cycles, from the acceptance edge to BUSY=0:
  - (WORD_W+1)*2*CLK_DIV for a non-last word.
  - (WORD_W+2)*2*CLK_DIV for a last word.
- Back-to-back words: ENA held high at the WORD_DONE cycle is accepted immediately. There is no idle gap between frames; TX_CLK stays low through the IDLE cycle.
- ENA while BUSY=1: no capture, no effect. The upstream must hold the word until BUSY=0.
- LAST is sampled only at acceptance; later changes are ignored.
- The half-period counter is sized for 255 and wraps to 0 at CLK_DIV-1.
- The bit counter is sized ceil(log2(WORD_W+1)).

Optional Feature:
- Macro: SPI_FRAME_TX_PARITY_EN.
- Defined:
  - An odd-parity bit (XOR of all captured bits, inverted) is sent as one extra bit period after the LSB and before LOAD.
  - Frame lengths grow by 2*CLK_DIV.
  - Parity is computed at capture.
- Undefined: no parity logic or parity bit period; timing is exactly as above.

Test Plan:
- CLK_DIV=2, DATA=0xA5C3, LAST=1, ENA pulse in IDLE:
  - TX_DATA sampled on 16 TX_CLK rises = 1010010111000011.
  - 17th rise has TX_LOAD=1; 18th rise has TX_STOP=1.
  - BUSY high 72 cycles, then WORD_DONE pulse.
- CLK_DIV=2, two words 0x0001 (LAST=0) then 0x8000 (LAST=1), ENA held high:
  - Second word accepted on the WORD_DONE cycle.
  - LOAD after each word, STOP only after the second.
  - Total 68+72 cycles.
- ENA pulsed with DATA=0xFFFF mid-frame of 0x1234:
  - Transmitted bits are still 0x1234.
  - 0xFFFF is never sent; BUSY is unaffected.
- RST asserted at the 5th bit of 0xFFFF:
  - Next cycle all outputs are 0 and BUSY=0.
  - No TX_LOAD/TX_STOP appears.
  - A fresh ENA of 0x00FF then transmits cleanly.
- CLK_DIV=1, DATA=0x0000, LAST=0: TX_CLK toggles every cycle, 17 rises total, BUSY high 34 cycles.
- With SPI_FRAME_TX_PARITY_EN, CLK_DIV=2, DATA=0x0003, LAST=1:
  - Parity bit (17th rise) = 1.
  - LOAD on the 18th rise, STOP on the 19th.
  - BUSY high 76 cycles.
